// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder and the MEM stage:
// FSM states, default latency, load/store opcodes and address checking.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned LATENCY_DEF = 2;
    localparam int unsigned CNT_W       = 4;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    // Word accesses only: low address bits must be zero and the word index in range.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the MEM stage and the data memory.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word array: byte-enabled synchronous write, combinational read.
// Contents are deliberately left unreset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [3:0][7:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][b] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, response held
// until the initiator consumes it.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              write_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              accept;
    logic              enter_resp;
    logic              cur_write;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_be;
    logic              cur_err;
    logic              arr_we;
    logic [31:0]       arr_rdata;
    logic [31:0]       resp_rdata_d;
    logic              resp_err_d;

    // With LATENCY=1 the array is touched on the acceptance edge itself, so the
    // live request fields are used in IDLE and the latched copy afterwards.
    always_comb begin
        accept       = (state_q == IDLE) && bus.req_valid;
        enter_resp   = (accept && (LATENCY == 1)) ||
                       ((state_q == WAIT) && (cnt_q <= 4'd1));
        cur_write    = (state_q == IDLE) ? bus.req_write : write_q;
        cur_addr     = (state_q == IDLE) ? bus.req_addr  : addr_q;
        cur_wdata    = (state_q == IDLE) ? bus.req_wdata : wdata_q;
        cur_be       = (state_q == IDLE) ? bus.req_be    : be_q;
        cur_err      = addr_err(cur_addr, DEPTH_WORDS);
        arr_we       = enter_resp && !rst && cur_write && !cur_err;
        resp_rdata_d = (cur_write || cur_err) ? 32'h0 : arr_rdata;
        resp_err_d   = cur_err;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .be_i    (cur_be),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        be_q        <= bus.req_be;
                        cnt_q       <= LAT_M1;
                        req_ready_q <= 1'b0;
                        if (enter_resp) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= resp_rdata_d;
                            resp_err_q   <= resp_err_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (enter_resp) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= resp_rdata_d;
                        resp_err_q   <= resp_err_d;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one LATENCY=2 and one LATENCY=1 instance,
// checked every cycle against a timing/memory model plus literal pins.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus1 ();

    logic [1:0]  rv, rw, rr;
    logic [31:0] ra [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic [1:0]  rdy, vld, er;
    logic [31:0] rd [2];

    assign bus2.req_valid = rv[0];
    assign bus2.req_write = rw[0];
    assign bus2.req_addr  = ra[0];
    assign bus2.req_wdata = wd[0];
    assign bus2.req_be    = be[0];
    assign bus2.resp_ready = rr[0];
    assign bus1.req_valid = rv[1];
    assign bus1.req_write = rw[1];
    assign bus1.req_addr  = ra[1];
    assign bus1.req_wdata = wd[1];
    assign bus1.req_be    = be[1];
    assign bus1.resp_ready = rr[1];
    assign rdy[0] = bus2.req_ready;
    assign vld[0] = bus2.resp_valid;
    assign rd[0]  = bus2.resp_rdata;
    assign er[0]  = bus2.resp_err;
    assign rdy[1] = bus1.req_ready;
    assign vld[1] = bus1.resp_valid;
    assign rd[1]  = bus1.resp_rdata;
    assign er[1]  = bus1.resp_err;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave));

    // Model: a request accepted at edge a has its effect at edge a+L-1 and its
    // response visible from then until the first edge that sees resp_ready.
    int          lat [2] = '{2, 1};
    bit          out_m [2];
    int          acc [2];
    logic        m_w [2];
    logic [31:0] m_a [2];
    logic [31:0] m_d [2];
    logic [3:0]  m_be [2];
    logic [31:0] exp_rd [2];
    logic        exp_err [2];
    logic [31:0] mm [2][DEPTH];

    int          cyc;
    bit          rst_edge;
    logic        prev_vld [2];
    int          last_rise [2];
    int          vld_cnt [2];
    int          hs_edge [2];
    logic [31:0] cap_rd [2];
    logic        cap_err [2];
    int          checks, errors;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout (cycle %0d)", nm, cyc);
    endtask

    task automatic model_update(input int g, input int k);
        int idx;
        if (rst) begin
            out_m[g] = 1'b0;
        end else begin
            if (out_m[g] && k >= acc[g] + lat[g] && rr[g]) begin
                out_m[g] = 1'b0;
            end else if (!out_m[g] && rv[g]) begin
                out_m[g] = 1'b1;
                acc[g]   = k;
                m_w[g]   = rw[g];
                m_a[g]   = ra[g];
                m_d[g]   = wd[g];
                m_be[g]  = be[g];
            end
            if (out_m[g] && k == acc[g] + lat[g] - 1) begin
                exp_err[g] = (m_a[g] % 4 != 0) || ((m_a[g] >> 2) >= DEPTH);
                idx = int'(m_a[g] >> 2);
                if (exp_err[g]) begin
                    exp_rd[g] = 32'h0;
                end else if (m_w[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[g][b]) mm[g][idx][8*b +: 8] = m_d[g][8*b +: 8];
                    exp_rd[g] = 32'h0;
                end else begin
                    exp_rd[g] = mm[g][idx];
                end
            end
        end
    endtask

    task automatic compare(input int g, input int k);
        logic ev;
        ev = out_m[g] && (k >= acc[g] + lat[g] - 1);
        chk($sformatf("req_ready[L%0d]", lat[g]), {31'b0, rdy[g]}, {31'b0, !out_m[g]});
        chk($sformatf("resp_valid[L%0d]", lat[g]), {31'b0, vld[g]}, {31'b0, ev});
        if (rst_edge) begin
            chk($sformatf("rst_rdata[L%0d]", lat[g]), rd[g], 32'h0);
            chk($sformatf("rst_err[L%0d]", lat[g]), {31'b0, er[g]}, 32'h0);
        end
        if (ev) begin
            if (!$isunknown(exp_rd[g]))
                chk($sformatf("resp_rdata[L%0d]", lat[g]), rd[g], exp_rd[g]);
            chk($sformatf("resp_err[L%0d]", lat[g]), {31'b0, er[g]}, {31'b0, exp_err[g]});
        end
        if (vld[g] === 1'b1) begin
            cap_rd[g]  = rd[g];
            cap_err[g] = er[g];
            vld_cnt[g]++;
            if (prev_vld[g] !== 1'b1) last_rise[g] = k;
        end
        prev_vld[g] = vld[g];
    endtask

    task automatic step();
        @(posedge clk);
        rst_edge = rst;
        for (int g = 0; g < 2; g++) model_update(g, cyc);
        @(negedge clk);
        for (int g = 0; g < 2; g++) compare(g, cyc);
        cyc++;
    endtask

    task automatic issue(input int g, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        int n = 0;
        rv[g] = 1'b1; rw[g] = w; ra[g] = a; wd[g] = d; be[g] = b;
        do begin step(); n++; end while (!(out_m[g] && acc[g] == cyc - 1) && n < 20);
        if (n >= 20) tmo("accept");
        rv[g] = 1'b0;
    endtask

    task automatic complete(input int g, input int hold, input bit ghost);
        int n = 0;
        while (!(out_m[g] && cyc - 1 >= acc[g] + lat[g] - 1) && n < 40) begin step(); n++; end
        if (n >= 40) tmo("resp_wait");
        if (ghost) begin rv[g] = 1'b1; rw[g] = 1'b0; ra[g] = 32'h10; be[g] = 4'h0; end
        repeat (hold) step();
        rr[g] = 1'b1;
        n = 0;
        do begin step(); n++; end while (out_m[g] && n < 20);
        if (n >= 20) tmo("handshake");
        hs_edge[g] = cyc - 1;
        rr[g] = 1'b0;
    endtask

    task automatic txn(input int g, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        issue(g, w, a, d, b);
        complete(g, 0, 1'b0);
    endtask

    initial begin
        int n, prev;
        logic [31:0] vals [4];
        vals = '{32'h0BAD_F00D, 32'hCAFE_0001, 32'h1357_9BDF, 32'h8000_0008};
        checks = 0; errors = 0; cyc = 0;
        rv = '0; rw = '0; rr = '0;
        for (int g = 0; g < 2; g++) begin
            ra[g] = '0; wd[g] = '0; be[g] = '0;
            last_rise[g] = -1; vld_cnt[g] = 0; prev_vld[g] = 1'b0;
            for (int i = 0; i < DEPTH; i++) mm[g][i] = 'x;
        end

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        while (cyc < 6) step();

        // Store accepted in cycle 5, response visible in cycle 7.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("acc_cycle", acc[0] - 1, 32'd5);
        complete(0, 0, 1'b0);
        chk("rise_cycle", last_rise[0], 32'd7);
        chk("sw_err", {31'b0, cap_err[0]}, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("lw_0x10", cap_rd[0], 32'hDEADBEEF);
        chk("model_0x10", exp_rd[0], 32'hDEADBEEF);

        // Partial store, then an all-disabled store that must change nothing.
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        txn(0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("lw_0x20_be", cap_rd[0], 32'h1122AA44);
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("lw_0x20_be0", cap_rd[0], 32'h1122AA44);

        // Error cases.
        txn(0, 1'b0, 32'h22, 32'h0, 4'h0);
        chk("mis_err", {31'b0, cap_err[0]}, 32'h1);
        chk("mis_rdata", cap_rd[0], 32'h0);
        txn(0, 1'b0, 4 * DEPTH, 32'h0, 4'h0);
        chk("oor_err", {31'b0, cap_err[0]}, 32'h1);
        txn(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
        txn(0, 1'b1, 32'h402, 32'hFFFFFFFF, 4'hF);
        chk("st402_err", {31'b0, cap_err[0]}, 32'h1);
        txn(0, 1'b1, 32'h400, 32'h5A5A5A5A, 4'hF);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("lw_0x0_kept", cap_rd[0], 32'hA5A5A5A5);

        // Back-pressure: 4 stalled cycles, a second request waiting meanwhile.
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
        vld_cnt[0] = 0;
        complete(0, 4, 1'b1);
        chk("stall_vld_cycles", vld_cnt[0], 32'd5);
        chk("stall_rdata", cap_rd[0], 32'h1122AA44);
        n = 0;
        do begin step(); n++; end while (!(out_m[0] && acc[0] == cyc - 1) && n < 20);
        if (n >= 20) tmo("ghost_accept");
        chk("ghost_acc_edge", acc[0], hs_edge[0] + 1);
        rv[0] = 1'b0;
        complete(0, 0, 1'b0);
        chk("ghost_rdata", cap_rd[0], 32'hDEADBEEF);

        // Reset while a store is in flight.
        txn(0, 1'b1, 32'h40, 32'h12345678, 4'hF);
        issue(0, 1'b1, 32'h40, 32'h00000055, 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vld_cnt[0] = 0;
        repeat (5) step();
        chk("rst_no_resp", vld_cnt[0], 32'd0);
        txn(0, 1'b0, 32'h40, 32'h0, 4'h0);
        chk("lw_0x40_prior", cap_rd[0], 32'h12345678);

        // LATENCY=1: back-to-back loads with resp_ready held high.
        for (int i = 0; i < 4; i++) txn(1, 1'b1, 32'(4 * i), vals[i], 4'hF);
        rr[1] = 1'b1;
        rv[1] = 1'b1; rw[1] = 1'b0; be[1] = 4'h0;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            ra[1] = 32'(4 * i);
            n = 0;
            do begin step(); n++; end while (!(out_m[1] && acc[1] == cyc - 1) && n < 20);
            if (n >= 20) tmo("b2b_accept");
            if (prev >= 0) chk("b2b_spacing", acc[1] - prev, 32'd2);
            chk("b2b_latency", last_rise[1], acc[1]);
            chk("b2b_rdata", cap_rd[1], vals[i]);
            prev = acc[1];
        end
        rv[1] = 1'b0;
        repeat (3) step();
        rr[1] = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
